// File: rtl/index_sweeper.sv
// index_sweeper: walks an index from base to limit by step and feeds
// an enable-gated downstream register, with stall hold and done pulse.
//
// Ports:
//   clk, rst          clock, async active-high reset
//   start             begin a sweep (sampled only while idle)
//   base/limit/step   sweep bounds and increment, captured on start
//   stall             downstream not ready; holds index, masks en
//   val               current index (holds last value while idle)
//   en                one-cycle load strobe per consumed index
//   busy              sweep in progress
//   done              one-cycle completion pulse
module index_sweeper #(
  parameter int size = 3
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [size-1:0] base,
  input  logic [size-1:0] limit,
  input  logic [size-1:0] step,
  input  logic            stall,
  output logic [size-1:0] val,
  output logic            en,
  output logic            busy,
  output logic            done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EMIT = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]      state;
  logic [size-1:0] cur;
  logic [size-1:0] lim_r;
  logic [size-1:0] step_r;
  logic [size:0]   nxt;
  logic            last;

  // One extra bit catches wrap-around past the top of the index range.
  assign nxt  = {1'b0, cur} + {1'b0, step_r};
  assign last = (step_r == '0)
              | nxt[size]
              | (nxt[size-1:0] > lim_r);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cur    <= '0;
      lim_r  <= '0;
      step_r <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cur    <= base;
            lim_r  <= limit;
            step_r <= step;
            state  <= (base <= limit) ? S_EMIT
                                      : S_DONE;
          end
        end
        S_EMIT: begin
          if (!stall) begin
            if (last) state <= S_DONE;
            else      cur   <= nxt[size-1:0];
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign en   = (state == S_EMIT) & ~stall;
  assign val  = cur;
  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_index_sweeper.sv
// tb_index_sweeper: randomized scoreboard bench for index_sweeper.
// Driver pushes expected strobes/done; monitor pops on each output.
module tb_index_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [2:0] base;
  logic [2:0] limit;
  logic [2:0] step;
  logic       stall;
  logic [2:0] val;
  logic       en;
  logic       busy;
  logic       done;

  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       is_done;
    logic [2:0] v;
  } ev_t;

  ev_t q[$];

  index_sweeper #(.size(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .base  (base),
    .limit (limit),
    .step  (step),
    .stall (stall),
    .val   (val),
    .en    (en),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, int got, int exp);
    checks++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, want %0d", name, got, exp);
  endtask

  // Monitor: consumes scoreboard entries whenever the DUT strobes.
  always @(negedge clk) begin
    if (!rst) begin
      if (en) begin
        if (q.size() == 0 || q[0].is_done) begin
          chk("spurious_en", int'(en), 0);
        end else begin
          ev_t e;
          e = q.pop_front();
          chk("en_val", int'(val), int'(e.v));
        end
      end
      if (done) begin
        if (q.size() == 0 || !q[0].is_done) begin
          chk("spurious_done", int'(done), 0);
        end else begin
          void'(q.pop_front());
          chk("done_expected", int'(done), 1);
        end
      end
      if (busy && stall && !done) begin
        chk("stall_masks_en", int'(en), 0);
        if (q.size() > 0 && !q[0].is_done)
          chk("stall_val", int'(val), int'(q[0].v));
      end
    end
  end

  // Reference: list of indices from plain integer arithmetic.
  // Call at a negedge with the DUT idle; returns at a negedge.
  task automatic run(int b, int l, int s,
                     int pct, int hold_idx, bit noise);
    int n, v, em, stalls, held;
    int lastv;
    n = 0;
    v = b;
    lastv = b;
    while (v <= l) begin
      q.push_back('{is_done: 1'b0, v: 3'(v)});
      lastv = v;
      n++;
      if (s == 0) break;
      v += s;
    end
    q.push_back('{is_done: 1'b1, v: 3'd0});
    start = 1'b1;
    base  = 3'(b);
    limit = 3'(l);
    step  = 3'(s);
    stall = 1'b0;
    @(posedge clk);
    #1;
    start  = 1'b0;
    em     = n;
    stalls = 0;
    held   = 0;
    for (int c = 0; c < 64; c++) begin
      stall = 1'b0;
      if (em > 0 && (n - em) == hold_idx && held < 2) begin
        stall = 1'b1;
        held++;
      end else if (stalls < 8 &&
                   $urandom_range(99) < pct) begin
        stall = 1'b1;
        stalls++;
      end
      if (noise) begin
        start = 1'($urandom);
        base  = 3'($urandom);
        limit = 3'($urandom);
        step  = 3'($urandom);
      end
      @(negedge clk);
      chk("busy_in_sweep", int'(busy), 1);
      if (em > 0) chk("done_early", int'(done), 0);
      else        chk("done_timing", int'(done), 1);
      @(posedge clk);
      #1;
      if (em == 0) break;
      if (!stall) em--;
    end
    start = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("idle_busy", int'(busy), 0);
    chk("idle_done", int'(done), 0);
    chk("idle_val_hold", int'(val), lastv);
  endtask

  task automatic abort_test();
    for (int i = 0; i < 4; i++)
      q.push_back('{is_done: 1'b0, v: 3'(i)});
    start = 1'b1;
    base  = 3'd0;
    limit = 3'd7;
    step  = 3'd1;
    stall = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_val", int'(val), 3);
    rst = 1'b1;
    #1;
    chk("abort_val", int'(val), 0);
    chk("abort_en", int'(en), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_pending", q.size(), 1);
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_busy", int'(busy), 0);
      chk("post_abort_done", int'(done), 0);
    end
    run(2, 2, 1, 0, -1, 1'b0);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    base  = '0;
    limit = '0;
    step  = '0;
    stall = 1'b0;
    #1;
    chk("rst_val", int'(val), 0);
    chk("rst_en", int'(en), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run(1, 5, 2, 0, -1, 1'b0);
    run(5, 7, 3, 0, -1, 1'b0);
    run(0, 3, 1, 0, 2, 1'b0);
    run(6, 2, 1, 0, -1, 1'b0);
    run(4, 7, 0, 0, -1, 1'b0);
    run(0, 7, 1, 0, -1, 1'b1);
    run(7, 7, 1, 50, -1, 1'b1);
    abort_test();

    for (int i = 0; i < 40; i++)
      run(int'($urandom_range(7)),
          int'($urandom_range(7)),
          int'($urandom_range(7)),
          30, -1, 1'($urandom));

    repeat (2) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
